load_store_unit: RTL and testbench
==================================

# load_store_unit

Multicycle load/store unit between the core datapath and the data memory port. It accepts one access request per transaction from the control FSM and drives a word-aligned memory request with byte enables. It waits for a memory acknowledge of arbitrary latency, then returns sign- or zero-extended load data, or a store completion, as a one-cycle response. It replaces the byte-slicing and extension of loads in the datapath and adds store byte-lane steering.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of ACCESS cycles without `mem_ack` before the transaction aborts with an error; 0 disables the timeout.
- `clk` in 1: clock.
- `reset` in 1: reset; synchronous, active-low.
- `req_valid` in 1: access request; sampled only when `req_ready`=1.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I size/sign encoding.
- `req_addr` in 32: byte address (ALU result).
- `req_wdata` in 32: store data (rs2).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_error` out 1: valid with `rsp_valid`; signals misaligned access, illegal funct3 or timeout.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_we` out 1: write strobe; only ever high together with `mem_req`.
- `mem_addr` out 32: word address; `req_addr` with bits [1:0] forced to 00.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory has completed the access this cycle.
- `mem_rdata` in 32: read word; valid in the cycle `mem_ack`=1.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid` the unit registers write, funct3, address and wdata.
  - Illegal funct3 (011, 110, 111; also 100 and 101 for stores) → RESP with error.
  - Misaligned access (see Configuration) → RESP with error.
  - Otherwise → ACCESS.
- **ACCESS**
  - `mem_req`=1 and `mem_we`=write; `mem_addr`, `mem_be` and `mem_wdata` stay stable for the whole state.
  - On `mem_ack`: load data is captured and extended → RESP.
  - Timeout counter reaches TIMEOUT_CYCLES → `mem_req` drops → RESP with error.
  - Ack and timeout in the same cycle: ack wins and there is no error.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle → IDLE.
- **Byte lanes** (`o` = `req_addr[1:0]`):
  - B: `mem_be` = 0001<<o; `mem_wdata` = {4{wdata[7:0]}}.
  - H: `mem_be` = o[1] ? 1100 : 0011; `mem_wdata` = {2{wdata[15:0]}}.
  - W: `mem_be` = 1111; `mem_wdata` = wdata.
  - Loads drive the same `mem_be` pattern.
- **Load extraction**:
  - The byte or half is selected from `mem_rdata` by `o`.
  - funct3 000/001 sign-extend; 100/101 zero-extend; 010 passes the word unchanged.

## Timing
- Request accepted at edge N. `mem_req` is high from cycle N+1.
- If `mem_ack` arrives at cycle N+k (k≥1), `rsp_valid` is high in cycle N+k+1.
- Minimum turnaround is 2 cycles; an error detected in IDLE gives `rsp_valid` at N+1 with no memory request.
- `req_ready` falls the cycle after acceptance. It returns high the cycle after `rsp_valid`, so there are no back-to-back overlaps.
- Reset values (after any clock edge with `reset`=0):
  - state IDLE, `req_ready`=1;
  - `rsp_valid`, `rsp_error`, `mem_req` and `mem_we` = 0;
  - `rsp_rdata`, `mem_addr`, `mem_wdata` = 0; `mem_be` = 0000; timeout counter = 0.
- Reset mid-ACCESS aborts the transaction at that edge with no response. A `mem_ack` arriving while `reset`=0 is ignored.
- `req_valid` is ignored outside IDLE and while `reset`=0.

## Configuration
- `LSU_MISALIGN_CHECK_EN`
  - **Defined**:
    - H accesses with `o[0]`≠0 and W accesses with `o`≠00 complete as errors.
    - No memory request is issued.
    - `rsp_valid`/`rsp_error` appear at N+1 and `rsp_rdata`=0.
  - **Undefined**:
    - Low address bits are truncated to natural alignment (H uses `o[1]`, W uses 00).
    - The access proceeds normally and `rsp_error` is set only on illegal funct3 or timeout.

## Structure
- In `src/types.svh`:
  - `lsu_state_t` enum (IDLE/ACCESS/RESP);
  - `byte_en_t` (4 bits);
  - funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`, `F3_SB`, `F3_SH`, `F3_SW`.
- One combinational sub-module, `lsu_lane_align`:
  - inputs: funct3, offset, wdata, rdata;
  - outputs: be, lane-replicated wdata, extended rdata, misaligned flag, illegal flag.
- FSM, timeout counter and registers stay in the top level.

## Test plan
- **Store byte**: SB with addr 0x0000_0103, wdata 0xAABB_CCDD, ack at k=1 → `mem_addr` 0x100, `mem_be` 1000, `mem_wdata` 0xDDDD_DDDD, `mem_we`=1; `rsp_valid` at N+2 with `rsp_error`=0.
- **Signed/unsigned loads with wait states**: LH addr 0x202, `mem_rdata` 0x8001_1234, ack at k=3 → `rsp_rdata` 0xFFFF_8001 at N+4. LHU at the same address → 0x0000_8001.
- **Misaligned access**: LW addr 0x105.
  - With the macro defined: `mem_req` never rises; `rsp_valid`=1, `rsp_error`=1 at N+1.
  - Without the macro: `mem_addr` 0x104 and the read completes normally.
- **Timeout**: TIMEOUT_CYCLES=4 and no ack → `mem_req` high for exactly 4 cycles, then `rsp_error`=1. A repeat with ack in the 4th cycle must complete with no error.
- **Reset mid-access**: `reset`=0 during ACCESS → next edge `mem_req`=0, `req_ready`=1, no `rsp_valid`. An ack pulse during reset produces no response.
- **Illegal funct3**: load with funct3 011 → error at N+1, no memory request; the next legal LB is accepted normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types, funct3 encodings and extension helpers for the load/store unit.
package load_store_unit_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
  typedef logic [3:0] byte_en_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    return 32'(v);
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    return 32'(v);
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering for stores and lane extraction/extension for loads.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output byte_en_t    be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  assign b_sel = rdata_i[{offset_i, 3'b000} +: 8];
  assign h_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // funct3[2] selects zero extension; half accesses ignore offset[0] (natural alignment)
  always_comb begin
    be_o       = '0;
    wdata_o    = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (funct3_i)
      F3_LB, F3_LBU: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = funct3_i[2] ? {24'b0, b_sel} : sext8(b_sel);
      end
      F3_LH, F3_LHU: begin
        be_o       = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = funct3_i[2] ? {16'b0, h_sel} : sext16(h_sel);
        misalign_o = offset_i[0];
      end
      F3_LW: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
        misalign_o = |offset_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: IDLE/ACCESS/RESP FSM with memory timeout.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses instead of truncating.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output byte_en_t    mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [2:0]  f3_sel;
  logic [1:0]  off_sel;
  byte_en_t    be;
  logic [31:0] wdata_lane, rdata_ext;
  logic        misalign, illegal, bad_align, reject;

  // In IDLE the aligner classifies the incoming request; afterwards it serves the held one
  assign f3_sel  = (state_q == IDLE) ? req_funct3 : funct3_q;
  assign off_sel = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];

  lsu_lane_align u_align (
    .funct3_i  (f3_sel),
    .offset_i  (off_sel),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .be_o      (be),
    .wdata_o   (wdata_lane),
    .rdata_o   (rdata_ext),
    .misalign_o(misalign),
    .illegal_o (illegal)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  assign bad_align = misalign;
`else
  assign bad_align = misalign & 1'b0;
`endif

  assign reject = illegal | (req_write & req_funct3[2]) | bad_align;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (reject) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // An ack in the final allowed cycle takes priority over the timeout
        if (mem_ack) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = write_q ? '0 : rdata_ext;
        end else if (TO_EN && (cnt_q == CNT_MAX)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held data needs no reset: every output that exposes it is gated by state
  always_ff @(posedge clk) begin
    write_q  <= write_d;
    funct3_q <= funct3_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    rdata_q  <= rdata_d;
    err_q    <= err_d;
  end

  assign req_ready = (state_q == IDLE);
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_req & write_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be : '0;
  assign mem_wdata = mem_req ? wdata_lane : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_error = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request for a single accepting edge and records the expected response
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic expect_rsp,
                       input logic [31:0] exp_rd, input logic exp_err);
    rsp_t r;
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    if (expect_rsp) begin
      r.rdata = exp_rd;
      r.err   = exp_err;
      exp_q.push_back(r);
    end
    tick();
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_rsp observed rdata %h err %b expected none", rsp_rdata, rsp_error);
      end
      if (exp_q.size() != 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
      end
    end
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    reset = 1'b1;
    tick();

    // Store byte at offset 3, ack at k=1
    issue(1'b1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 1'b1, 32'h0, 1'b0);
    chk("sb_ready", {31'b0, req_ready}, 32'd0);
    chk("sb_mem_req", {31'b0, mem_req}, 32'd1);
    chk("sb_mem_we", {31'b0, mem_we}, 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_0100);
    chk("sb_be", {28'b0, mem_be}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sb_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("sb_req_dropped", {31'b0, mem_req}, 32'd0);
    tick();
    chk("sb_ready_back", {31'b0, req_ready}, 32'd1);

    // Store half at offset 2
    issue(1'b1, 3'b001, 32'h0000_0602, 32'h1234_ABCD, 1'b1, 32'h0, 1'b0);
    chk("sh_be", {28'b0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();

    // Signed half load with three wait cycles
    issue(1'b0, 3'b001, 32'h0000_0202, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0);
    chk("lh_be", {28'b0, mem_be}, 32'hC);
    chk("lh_we", {31'b0, mem_we}, 32'd0);
    tick();
    chk("lh_wait2", {31'b0, mem_req}, 32'd1);
    tick();
    chk("lh_wait3", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h8001_1234;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("lh_rsp_at_n4", {31'b0, rsp_valid}, 32'd1);
    tick();

    // Unsigned half load, same address
    issue(1'b0, 3'b101, 32'h0000_0202, 32'h0, 1'b1, 32'h0000_8001, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h8001_1234;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick();

    // Misaligned word load
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b0, 3'b010, 32'h0000_0105, 32'h0, 1'b1, 32'h0, 1'b1);
    chk("mis_no_req", {31'b0, mem_req}, 32'd0);
    chk("mis_rsp_n1", {31'b0, rsp_valid}, 32'd1);
    tick();
`else
    issue(1'b0, 3'b010, 32'h0000_0105, 32'h0, 1'b1, 32'h1122_3344, 1'b0);
    chk("mis_addr", mem_addr, 32'h0000_0104);
    chk("mis_be", {28'b0, mem_be}, 32'hF);
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
`endif

    // Timeout: no ack for four access cycles
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_high", {31'b0, mem_req}, 32'd1);
      tick();
    end
    chk("to_req_low", {31'b0, mem_req}, 32'd0);
    chk("to_rsp", {31'b0, rsp_valid}, 32'd1);
    tick();

    // Ack in the fourth cycle beats the timeout
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("to2_req_high", {31'b0, mem_req}, 32'd1);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("to2_rsp", {31'b0, rsp_valid}, 32'd1);
    tick();

    // Reset in the middle of an access; ack and request during reset are ignored
    issue(1'b0, 3'b000, 32'h0000_0400, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("rmid_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b0; mem_ack = 1'b1;
    tick();
    chk("rmid_req_low", {31'b0, mem_req}, 32'd0);
    chk("rmid_ready", {31'b0, req_ready}, 32'd1);
    chk("rmid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    req_valid = 1'b1;
    tick();
    chk("rmid_held_idle", {31'b0, mem_req}, 32'd0);
    chk("rmid_no_rsp2", {31'b0, rsp_valid}, 32'd0);
    req_valid = 1'b0; mem_ack = 1'b0; reset = 1'b1;
    tick();
    chk("rmid_after", {31'b0, rsp_valid}, 32'd0);

    // Illegal load funct3, then illegal store funct3, then a legal LB
    issue(1'b0, 3'b011, 32'h0000_0500, 32'h0, 1'b1, 32'h0, 1'b1);
    chk("ill_no_req", {31'b0, mem_req}, 32'd0);
    chk("ill_rsp_n1", {31'b0, rsp_valid}, 32'd1);
    tick();
    issue(1'b1, 3'b100, 32'h0000_0500, 32'h55, 1'b1, 32'h0, 1'b1);
    chk("ills_no_req", {31'b0, mem_req}, 32'd0);
    tick();
    issue(1'b0, 3'b000, 32'h0000_0501, 32'h0, 1'b1, 32'hFFFF_FFF7, 1'b0);
    chk("lb_be", {28'b0, mem_be}, 32'h2);
    chk("lb_addr", mem_addr, 32'h0000_0500);
    mem_ack = 1'b1; mem_rdata = 32'h0000_F700;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();

    chk("drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
